// File: rtl/dbg_cmd_sequencer_if.sv
// Purpose : groups the byte-link, latch command and latch response signals of the debug sequencer.
// Latency : none (wires only).
// Backpressure: none; rx/tx/cmd are single-cycle strobes, tx pacing is by tx_done.
// master  : the sequencer side (consumes rx bytes and latch data, drives command and tx bytes).
// slave   : the environment side (UART rx/tx pair plus debug latch).
interface dbg_cmd_sequencer_if #(
    parameter int NB_BITS = 32,
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] rx_data;
    logic               rx_valid;
    logic [NB_BITS-1:0] cmd;
    logic               cmd_valid;
    logic [NB_BITS-1:0] resp;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               busy;
    logic               drop;

    modport master (
        input  rx_data, rx_valid, resp, tx_done,
        output cmd, cmd_valid, tx_data, tx_start, busy, drop
    );

    modport slave (
        output rx_data, rx_valid, resp, tx_done,
        input  cmd, cmd_valid, tx_data, tx_start, busy, drop
    );
endinterface

// File: rtl/dbg_cmd_sequencer.sv
// Purpose : assembles 4 link bytes (big-endian) into a debug command, pulses it to the latch,
//           waits for the latch to settle and, for read opcodes 4/5/6, returns its data as 4 bytes.
// Latency : cmd_valid 1 cycle after the 4th byte; first tx_start NB_WAIT+2 cycles after cmd_valid.
// Backpressure: none on rx (bytes outside COLLECT are dropped and flagged sticky in drop);
//           tx is paced one byte per tx_start/tx_done pair with no timeout.
// Ports   : i_clk, i_rst (async, active-low); bus = dbg_cmd_sequencer_if.master
//           (rx_data/rx_valid in, cmd/cmd_valid out, resp in, tx_data/tx_start out,
//            tx_done in, busy/drop status out).
module dbg_cmd_sequencer #(
    parameter int NB_BITS = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_OPC  = 16,
    parameter int NB_WAIT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dbg_cmd_sequencer_if.master   bus
);

    localparam int WCNT_W = $clog2(NB_WAIT);
    localparam int REST_W = NB_BITS - NB_BYTE;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ISSUE,
        S_SETTLE,
        S_CAPTURE,
        S_TX_START,
        S_TX_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [1:0]          byte_cnt;
    logic [1:0]          tx_cnt;
    logic [WCNT_W-1:0]   wait_cnt;
    // Only the first three bytes need storing; the 4th comes straight off rx_data.
    logic [REST_W-1:0]   asm_lo;
    logic [NB_BITS-1:0]  cmd_word;
    // Bytes still to send after the one currently on tx_data.
    logic [REST_W-1:0]   tx_rest;
    logic [NB_BYTE-1:0]  tx_byte;
    logic                drop_flag;

    logic [NB_OPC-1:0]   opcode;
    logic                is_read;
    logic                rx_accept;
    logic                last_byte;
    logic                tx_adv;

    logic                cmd_valid_c;
    logic                tx_start_c;
    logic                busy_c;

    assign opcode    = cmd_word[NB_BITS-1 -: NB_OPC];
    assign is_read   = (opcode == NB_OPC'(4)) || (opcode == NB_OPC'(5)) ||
                       (opcode == NB_OPC'(6));
    assign rx_accept = (state == S_COLLECT) && bus.rx_valid;
    assign last_byte = rx_accept && (byte_cnt == 2'd3);
    assign tx_adv    = (state == S_TX_WAIT) && bus.tx_done;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        state_nxt   = state;
        cmd_valid_c = 1'b0;
        tx_start_c  = 1'b0;
        busy_c      = 1'b1;
        case (state)
            S_COLLECT: begin
                busy_c = 1'b0;
                if (last_byte) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ISSUE always lasts exactly one cycle, so the strobe can never repeat back to back.
                cmd_valid_c = 1'b1;
                state_nxt   = S_SETTLE;
            end
            S_SETTLE: begin
                if (wait_cnt == '0) begin
                    state_nxt = is_read ? S_CAPTURE : S_COLLECT;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_TX_START;
            end
            S_TX_START: begin
                tx_start_c = 1'b1;
                state_nxt  = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (bus.tx_done) begin
                    state_nxt = (tx_cnt == 2'd3) ? S_COLLECT : S_TX_START;
                end
            end
            default: begin
                state_nxt = S_COLLECT;
            end
        endcase
    end

    // Datapath: assembly, command hold, settle counter, tx shift, drop flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            byte_cnt  <= 2'd0;
            tx_cnt    <= 2'd0;
            wait_cnt  <= '0;
            asm_lo    <= '0;
            cmd_word  <= '0;
            tx_rest   <= '0;
            tx_byte   <= '0;
            drop_flag <= 1'b0;
        end else begin
            if (rx_accept) begin
                asm_lo   <= {asm_lo[REST_W-NB_BYTE-1:0], bus.rx_data};
                // Two-bit counter wraps to 0 on the 4th byte.
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (last_byte) begin
                cmd_word <= {asm_lo, bus.rx_data};
            end

            if (state == S_ISSUE) begin
                wait_cnt <= WCNT_W'(NB_WAIT - 1);
            end else if ((state == S_SETTLE) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (state == S_CAPTURE) begin
                tx_byte <= bus.resp[NB_BITS-1 -: NB_BYTE];
                tx_rest <= bus.resp[REST_W-1:0];
                tx_cnt  <= 2'd0;
            end else if (tx_adv) begin
                // After the last byte tx_data keeps its final value.
                if (tx_cnt != 2'd3) begin
                    tx_byte <= tx_rest[REST_W-1 -: NB_BYTE];
                end
                tx_rest <= tx_rest << NB_BYTE;
                tx_cnt  <= tx_cnt + 2'd1;
            end

            if (bus.rx_valid && (state != S_COLLECT)) begin
                drop_flag <= 1'b1;
            end
        end
    end

    assign bus.cmd       = cmd_word;
    assign bus.cmd_valid = cmd_valid_c;
    assign bus.tx_data   = tx_byte;
    assign bus.tx_start  = tx_start_c;
    assign bus.busy      = busy_c;
    assign bus.drop      = drop_flag;

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Purpose : randomized scoreboard bench for dbg_cmd_sequencer.
// Latency : expected command/tx timing derived from byte send times.
// Backpressure: a responder returns tx_done 2..5 cycles after each tx_start.
module tb_dbg_cmd_sequencer;
    localparam int NB_BITS = 32;
    localparam int NB_BYTE = 8;
    localparam int NB_OPC  = 16;
    localparam int NB_WAIT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbg_cmd_sequencer_if #(.NB_BITS(NB_BITS), .NB_BYTE(NB_BYTE)) bus ();

    dbg_cmd_sequencer #(
        .NB_BITS(NB_BITS), .NB_BYTE(NB_BYTE), .NB_OPC(NB_OPC), .NB_WAIT(NB_WAIT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    logic rsp_done   = 1'b0;
    logic stray_done = 1'b0;
    assign bus.tx_done = rsp_done | stray_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rst_gen = 0;
    bit exp_drop = 1'b0;

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [31:0] cmd;
        logic        rd;
        int          t4;
    } cmd_exp_t;

    cmd_exp_t    exp_cmds[$];
    logic [7:0]  exp_tx[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference rule: opcode is the upper 16 bits; 4, 5 and 6 are reads.
    function automatic bit model_is_read(input logic [31:0] w);
        int op;
        op = int'(w / 65536);
        return (op >= 4) && (op <= 6);
    endfunction

    // ---------------- monitor ----------------
    bit  prev_cv      = 1'b0;
    int  tx_due       = 0;
    bit  tx_first     = 1'b0;
    int  bytes_sent   = 0;
    bit  tx_final     = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cv    = 1'b0;
            tx_first   = 1'b0;
            bytes_sent = 0;
        end else begin
            if (bus.cmd_valid) begin
                check("cmd_valid_back_to_back", {31'd0, prev_cv}, 32'd0);
                if (exp_cmds.size() == 0) begin
                    check("unexpected_cmd_valid", 32'd1, 32'd0);
                end else begin
                    cmd_exp_t e;
                    e = exp_cmds.pop_front();
                    check("cmd", bus.cmd, e.cmd);
                    check("cmd_latency", cyc, e.t4 + 1);
                    if (e.rd) begin
                        tx_first = 1'b1;
                        tx_due   = cyc + NB_WAIT + 2;
                    end
                end
            end
            if (bus.tx_start) begin
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx_start", 32'd1, 32'd0);
                end else begin
                    logic [7:0] b;
                    b = exp_tx.pop_front();
                    check("tx_data", {24'd0, bus.tx_data}, {24'd0, b});
                    if (tx_first) begin
                        check("tx_latency", cyc, tx_due);
                        tx_first = 1'b0;
                    end
                    bytes_sent++;
                    tx_final = (bytes_sent == 4);
                    if (bytes_sent == 4) bytes_sent = 0;
                end
            end
            prev_cv = bus.cmd_valid;
        end
    end

    // ---------------- tx responder ----------------
    initial begin
        forever begin
            if (rst_n && bus.tx_start) begin
                int d;
                int g;
                bit fin;
                g = rst_gen;
                d = int'($urandom_range(2, 5));
                repeat (d - 1) @(negedge clk);
                rsp_done = 1'b1;
                if (g == rst_gen && rst_n) check("busy_in_tx_wait", {31'd0, bus.busy}, 32'd1);
                fin = tx_final;
                @(negedge clk);
                rsp_done = 1'b0;
                if (fin && g == rst_gen && rst_n) check("busy_after_last_done", {31'd0, bus.busy}, 32'd0);
            end else begin
                @(negedge clk);
            end
        end
    end

    // ---------------- driver helpers (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w, input logic [31:0] r, input bit gaps);
        cmd_exp_t e;
        bus.resp = r;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] sh;
            sh = w >> (24 - 8 * i);
            if (i == 3) begin
                e.cmd = w;
                e.rd  = model_is_read(w);
                e.t4  = cyc;
                exp_cmds.push_back(e);
                if (e.rd) begin
                    for (int k = 0; k < 4; k++) begin
                        logic [31:0] rs;
                        rs = r >> (24 - 8 * k);
                        exp_tx.push_back(rs[7:0]);
                    end
                end
            end
            send_byte(sh[7:0]);
            if (gaps && i < 3) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_tx_start();
        int k;
        k = 0;
        while (!bus.tx_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("tx_start_timeout", 32'd1, 32'd0);
    endtask

    // Write command, then the minimum gap before the link is accepted again.
    task automatic write_cmd(input logic [31:0] w);
        send_cmd(w, $urandom, 1'b1);
        repeat (3) @(negedge clk);
        check("busy_after_write", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rst_gen++;
        exp_tx.delete();
        exp_cmds.delete();
        exp_drop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        finish_run();
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.resp     = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd",       bus.cmd, 32'd0);
        check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_tx_data",   {24'd0, bus.tx_data}, 32'd0);
        check("rst_tx_start",  {31'd0, bus.tx_start}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy}, 32'd0);
        check("rst_drop",      {31'd0, bus.drop}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial word discarded by reset
        send_byte(8'h00);
        send_byte(8'h04);
        do_reset();
        send_cmd(32'h0004_0000, 32'h1234_5678, 1'b0);
        wait_idle();
        check("drop_after_reset_cmd", {31'd0, bus.drop}, 32'd0);

        // Read PC
        send_cmd(32'h0004_0000, 32'h1234_5678, 1'b0);
        wait_idle();

        // Back-to-back writes
        write_cmd(32'h0001_0005);
        write_cmd(32'h0002_BEEF);
        write_cmd(32'h0003_DEAD);

        // Byte during TX_WAIT is dropped; response still completes
        send_cmd(32'h0006_0000, 32'hCAFE_F00D, 1'b1);
        wait_tx_start();
        @(negedge clk);
        send_byte(8'hAA);
        exp_drop = 1'b1;
        wait_idle();
        check("drop_in_tx_wait", {31'd0, bus.drop}, 32'd1);
        send_cmd(32'h0005_0000, 32'h0BAD_BEEF, 1'b0);
        wait_idle();

        // Unknown opcode: no transmit
        write_cmd(32'h0007_0000);

        // Stray tx_done in COLLECT, then across ISSUE/SETTLE of a read
        stray_done = 1'b1;
        repeat (2) @(negedge clk);
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        send_cmd(32'h0004_0000, 32'h89AB_CDEF, 1'b0);
        stray_done = 1'b1;
        repeat (2) @(negedge clk);
        stray_done = 1'b0;
        wait_idle();

        // Reset mid-transmit: no further tx_start, flags cleared
        send_cmd(32'h0006_0000, 32'h5555_AAAA, 1'b0);
        wait_tx_start();
        @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check("busy_after_tx_reset", {31'd0, bus.busy}, 32'd0);
        check("drop_after_tx_reset", {31'd0, bus.drop}, 32'd0);

        // Byte on the last SETTLE cycle of a write is dropped; next byte is accepted
        send_cmd(32'h0001_1234, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        send_byte(8'hAA);
        exp_drop = 1'b1;
        send_cmd(32'h0002_5678, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("drop_last_settle", {31'd0, bus.drop}, 32'd1);

        // Randomized commands
        for (int n = 0; n < 30; n++) begin
            logic [31:0] w;
            logic [15:0] op;
            logic [15:0] arg;
            int r;
            r   = int'($urandom_range(0, 9));
            op  = (r < 8) ? 16'(r) : 16'($urandom);
            arg = 16'($urandom);
            w   = {op, arg};
            if (model_is_read(w)) begin
                send_cmd(w, $urandom, 1'b1);
                wait_idle();
            end else if ($urandom_range(0, 1) == 1) begin
                send_cmd(w, $urandom, 1'b1);
                repeat (2) @(negedge clk);
                send_byte(8'($urandom));
                exp_drop = 1'b1;
            end else begin
                write_cmd(w);
            end
        end

        repeat (10) @(negedge clk);
        check("pending_cmds", exp_cmds.size(), 32'd0);
        check("pending_tx",   exp_tx.size(), 32'd0);
        check("drop_final",   {31'd0, bus.drop}, {31'd0, exp_drop});
        finish_run();
    end
endmodule
